// File: rtl/ultrasound_pkg.sv
// Shared ultrasound definitions.
// Holds the transmit/receive sequencing state encodings and a width helper used to size
// delay and counter fields. The receive-side modules use the same encodings.
package ultrasound_pkg;

  // Sequencer states; the values are visible on debug_state.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StFire = 2'd2,
    StDone = 2'd3
  } bf_state_e;

  // clog2 that never returns 0, so a field sized by it is always at least one bit wide.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/tx_channel_pulser.sv
// Per-channel bipolar burst generator.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   fire        high when the next cycle belongs to the FIRE window
//   t           tick count the next cycle will carry
//   dly         snapshot delay of this channel
//   tx_p, tx_n  pulser drives; never both high
// fire and t describe the upcoming cycle, so the burst registers are already loaded in the
// cycle where t equals dly. A channel with zero delay therefore drives in the t = 0 cycle.
module tx_channel_pulser
  import ultrasound_pkg::*;
#(
  parameter int unsigned T_W      = 10,
  parameter int unsigned DLY_W    = 8,
  parameter int unsigned HALF_PER = 4,
  parameter int unsigned N_CYC    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fire,
  input  logic [T_W-1:0]   t,
  input  logic [DLY_W-1:0] dly,
  output logic             tx_p,
  output logic             tx_n
);

  localparam int unsigned HW = clog2_min1(HALF_PER);
  localparam int unsigned IW = clog2_min1(2 * N_CYC);

  logic          active_q, active_d;
  logic [HW-1:0] half_q, half_d;  // cycle within the current half-period
  logic [IW-1:0] idx_q, idx_d;    // half-period index within the burst; bit 0 is polarity

  always_comb begin
    active_d = active_q;
    half_d   = half_q;
    idx_d    = idx_q;
    if (!fire) begin
      active_d = 1'b0;
      half_d   = '0;
      idx_d    = '0;
    end else if (!active_q) begin
      half_d = '0;
      idx_d  = '0;
      if (t == T_W'(dly)) active_d = 1'b1;
    end else if (half_q == HW'(HALF_PER - 1)) begin
      half_d = '0;
      if (idx_q == IW'(2 * N_CYC - 1)) begin
        active_d = 1'b0;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      half_d = half_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      half_q   <= '0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      half_q   <= half_d;
      idx_q    <= idx_d;
    end
  end

  // Both drives decode from flops only, and the polarity bit keeps them exclusive.
  assign tx_p = active_q & ~idx_q[0];
  assign tx_n = active_q & idx_q[0];

endmodule

// File: rtl/tx_beam_fire.sv
// Focused transmit burst sequencer.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         level input; a burst fires on its 0->1 edge while idle
//   dly_we/addr/data  delay-table write port (low DLY_W bits of dly_data are kept)
//   tx_p, tx_n    per-channel pulser drives
//   rx_trig       one-cycle pulse at t = 0 of FIRE
//   busy          high in ARM and FIRE
//   done          one-cycle pulse in DONE
//   debug_state   current sequencer state
module tx_beam_fire
  import ultrasound_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned MAX_DLY  = 256,
  parameter int unsigned HALF_PER = 4,
  parameter int unsigned N_CYC    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          dly_we,
  input  logic [clog2_min1(N_CH)-1:0]   dly_addr,
  input  logic [DW-1:0]                 dly_data,
  output logic [N_CH-1:0]               tx_p,
  output logic [N_CH-1:0]               tx_n,
  output logic                          rx_trig,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    debug_state
);

  localparam int unsigned DLY_W  = clog2_min1(MAX_DLY);
  localparam int unsigned BURST  = 2 * HALF_PER * N_CYC;
  localparam int unsigned T_LAST = MAX_DLY + BURST - 1;
  // One spare bit so t never wraps inside FIRE.
  localparam int unsigned T_W    = $clog2(MAX_DLY + BURST) + 1;

  bf_state_e        state_q, state_d;
  logic [T_W-1:0]   t_q, t_d;
  logic             start_q;
  logic             start_rise;
  logic             rx_trig_q;
  logic [DLY_W-1:0] dly_tab_q [N_CH];
  logic [DLY_W-1:0] snap_q    [N_CH];

  logic unused_dly_hi;
  assign unused_dly_hi = ^dly_data[DW-1:DLY_W];

  assign start_rise = start & ~start_q;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      StIdle: if (start_rise) state_d = StArm;
      StArm: begin
        t_d     = '0;
        state_d = StFire;
      end
      StFire: begin
        t_d = t_q + T_W'(1);
        if (t_q == T_W'(T_LAST)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      t_q       <= '0;
      start_q   <= 1'b0;
      rx_trig_q <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        dly_tab_q[i] <= '0;
        snap_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      start_q   <= start;
      // ARM always leads into the t = 0 FIRE cycle.
      rx_trig_q <= (state_q == StArm);
      if (dly_we && (32'(dly_addr) < N_CH)) dly_tab_q[dly_addr] <= dly_data[DLY_W-1:0];
      // Snapshot takes the pre-write table, so a same-cycle write waits for the next burst.
      if ((state_q == StIdle) && start_rise) snap_q <= dly_tab_q;
    end
  end

  // Pulsers see the upcoming cycle so their registered outputs line up with t.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    tx_channel_pulser #(
      .T_W      (T_W),
      .DLY_W    (DLY_W),
      .HALF_PER (HALF_PER),
      .N_CYC    (N_CYC)
    ) u_pulser (
      .clk   (clk),
      .reset (reset),
      .fire  (state_d == StFire),
      .t     (t_d),
      .dly   (snap_q[i]),
      .tx_p  (tx_p[i]),
      .tx_n  (tx_n[i])
    );
  end

  assign rx_trig     = rx_trig_q;
  assign busy        = (state_q == StArm) || (state_q == StFire);
  assign done        = (state_q == StDone);
  assign debug_state = state_q;

endmodule

// File: tb/tb_tx_beam_fire.sv
// Directed bench for tx_beam_fire: reset, delayed bursts, held start, mid-burst table
// write, mid-burst reset and equal delays, with waveforms checked against a t-based model.
module tb_tx_beam_fire;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dly_we = 1'b0;
  logic [1:0]  dly_addr = '0;
  logic [15:0] dly_data = '0;
  logic [3:0]  tx_p, tx_n;
  logic        rx_trig, busy, done;
  logic [1:0]  debug_state;

  int checks = 0;
  int errors = 0;
  logic inv_en = 1'b0;

  logic [3:0] rp [272];
  logic [3:0] rn [272];
  int done_k;

  always #5 clk = ~clk;

  tx_beam_fire dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dly_we      (dly_we),
    .dly_addr    (dly_addr),
    .dly_data    (dly_data),
    .tx_p        (tx_p),
    .tx_n        (tx_n),
    .rx_trig     (rx_trig),
    .busy        (busy),
    .done        (done),
    .debug_state (debug_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Exclusive drive must hold in every cycle.
  always @(negedge clk) begin
    if (inv_en) chk("tx_p&tx_n", 32'(tx_p & tx_n), 0);
  end

  function automatic logic exp_p(input int t, input int d);
    if (t >= d && t < d + 16) return (((t - d) / 4) % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic exp_n(input int t, input int d);
    if (t >= d && t < d + 16) return (((t - d) / 4) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic load(input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] dv [4];
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    for (int i = 0; i < 4; i++) begin
      dly_we = 1'b1; dly_addr = 2'(i); dly_data = dv[i];
      tick();
    end
    dly_we = 1'b0;
  endtask

  // Drop start for a cycle, raise it, then record one whole FIRE window.
  task automatic capture(input int wr_t, input logic [1:0] wa, input logic [15:0] wd);
    int extra;
    extra = 0;
    done_k = -1;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("arm rx_trig", 32'(rx_trig), 0);
    chk("arm state", 32'(debug_state), 1);
    chk("arm busy", 32'(busy), 1);
    tick();
    chk("rx_trig at 2 clks", 32'(rx_trig), 1);
    chk("fire state", 32'(debug_state), 2);
    for (int k = 0; k < 400; k++) begin
      if (k > 0) tick();
      if (done) begin
        done_k = k;
        break;
      end
      if (k < 272) begin
        rp[k] = tx_p;
        rn[k] = tx_n;
      end
      if (k > 0 && rx_trig) extra++;
      dly_we = (k == wr_t); dly_addr = wa; dly_data = wd;
    end
    dly_we = 1'b0;
    chk("done latency", 32'(done_k), 272);
    chk("single rx_trig", 32'(extra), 0);
  endtask

  task automatic check_waves(input int d0, input int d1, input int d2, input int d3);
    int d [4];
    int errs;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int c = 0; c < 4; c++) begin
      errs = 0;
      for (int t = 0; t < 272; t++) begin
        if (rp[t][c] !== exp_p(t, d[c])) errs++;
        if (rn[t][c] !== exp_n(t, d[c])) errs++;
      end
      chk($sformatf("wave ch%0d dly %0d", c, d[c]), 32'(errs), 0);
    end
  endtask

  initial begin
    int held_busy;
    int nonuni;

    // Reset held for two clocks.
    tick();
    tick();
    chk("rst tx_p", 32'(tx_p), 0);
    chk("rst tx_n", 32'(tx_n), 0);
    chk("rst rx_trig", 32'(rx_trig), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst state", 32'(debug_state), 0);
    inv_en = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    chk("idle busy", 32'(busy), 0);
    chk("idle state", 32'(debug_state), 0);

    // Delays {0,3,7,255}; ch1 carries junk in the ignored upper bits.
    load(16'h0000, 16'hFF03, 16'h0007, 16'h00FF);
    capture(-1, 2'd0, 16'h0);
    check_waves(0, 3, 7, 255);

    // Start stays high: no further burst.
    held_busy = 0;
    repeat (330) begin
      tick();
      if (busy) held_busy++;
    end
    chk("held start one burst", 32'(held_busy), 0);
    capture(-1, 2'd0, 16'h0);
    check_waves(0, 3, 7, 255);

    // Write ch2 = 50 at t = 10: current burst keeps 7, next uses 50.
    capture(10, 2'd2, 16'd50);
    check_waves(0, 3, 7, 255);
    capture(-1, 2'd0, 16'h0);
    check_waves(0, 3, 50, 255);

    // Reset at t = 5 of a burst.
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    tick();
    repeat (5) tick();
    chk("pre-reset busy", 32'(busy), 1);
    chk("pre-reset ch0 tx_n", 32'(tx_n[0]), 1);
    reset = 1'b1;
    tick();
    chk("mid rst tx_p", 32'(tx_p), 0);
    chk("mid rst tx_n", 32'(tx_n), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst rx_trig", 32'(rx_trig), 0);
    chk("mid rst done", 32'(done), 0);
    chk("mid rst state", 32'(debug_state), 0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    capture(-1, 2'd0, 16'h0);
    check_waves(0, 0, 0, 0);

    // All delays equal: channels bit-identical.
    load(16'd20, 16'd20, 16'd20, 16'd20);
    capture(-1, 2'd0, 16'h0);
    check_waves(20, 20, 20, 20);
    nonuni = 0;
    for (int t = 0; t < 272; t++) begin
      if (!(rp[t] == 4'h0 || rp[t] == 4'hF)) nonuni++;
      if (!(rn[t] == 4'h0 || rn[t] == 4'hF)) nonuni++;
    end
    chk("channels identical", 32'(nonuni), 0);

    start = 1'b0;
    repeat (3) tick();
    chk("final idle state", 32'(debug_state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
